// File: rtl/insn_encode_loader_pkg.sv
// Shared constants and types for the instruction encode/loader block.
// Provides RV32I opcode/funct3 constants, the decoded-field payload struct,
// error-code and FSM state enums, the default load base address and an
// immediate range helper.
package insn_encode_loader_pkg;

    localparam int unsigned ILEN   = 32;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_W   = 7;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b011_0111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b110_1111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b110_0111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b010_0011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b011_0011;

    localparam logic [F3_W-1:0] F3_SLLI  = 3'b001;
    localparam logic [F3_W-1:0] F3_SRXI  = 3'b101;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0100_0000;

    // Decoded register/function fields of one instruction (immediate carried separately).
    typedef struct packed {
        logic [F7_W-1:0]  funct7;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rs1;
        logic [F3_W-1:0]  funct3;
        logic [REG_W-1:0] rd;
        logic [OPC_W-1:0] opcode;
    } insn_fields_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_OPCODE = 2'b01,
        ERR_IMM    = 2'b10,
        ERR_SHIFT  = 2'b11
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // True when v is the sign extension of its low nbits bits.
    function automatic logic fits_signed(input logic [ILEN-1:0] v, input int unsigned nbits);
        logic [ILEN-1:0] mask;
        mask = '1 << (nbits - 1);
        return ((v & mask) == '0) || ((v & mask) == mask);
    endfunction

endpackage

// File: rtl/insn_encode_loader_if.sv
// Tuple-input and memory-write channels of the encode/loader.
//   master: program source + instruction memory (drives tuples, accepts writes)
//   slave : the loader (accepts tuples, issues writes)
interface insn_encode_loader_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic              in_last_i;
    logic [6:0]        opcode_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic [DWIDTH-1:0] imm_i;

    logic              wr_valid_o;
    logic              wr_ready_i;
    logic [AWIDTH-1:0] wr_addr_o;
    logic [DWIDTH-1:0] wr_data_o;

    modport master (
        output in_valid_i, in_last_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
        output wr_ready_i,
        input  in_ready_o, wr_valid_o, wr_addr_o, wr_data_o
    );

    modport slave (
        input  in_valid_i, in_last_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
        input  wr_ready_i,
        output in_ready_o, wr_valid_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/insn_encode_loader_insn_pack.sv
// insn_pack: combinational RV32I encoder and immediate range checker.
//   fields_i   : decoded opcode/rd/rs1/rs2/funct3/funct7
//   imm_i      : sign-extended immediate in decode form
//   word_c     : packed 32-bit instruction word
//   err_code_c : ERR_NONE when the tuple is encodable, else the reason
module insn_pack
    import insn_encode_loader_pkg::*;
(
    input  insn_fields_t    fields_i,
    input  logic [ILEN-1:0] imm_i,
    output logic [ILEN-1:0] word_c,
    output err_code_e       err_code_c
);

    logic is_shift;
    assign is_shift = (fields_i.funct3 == F3_SLLI) || (fields_i.funct3 == F3_SRXI);

    // Format selection by opcode; shifts reuse funct7 as the upper immediate field.
    always_comb begin
        word_c     = '0;
        err_code_c = ERR_NONE;
        case (fields_i.opcode)
            OPC_OP: begin
                word_c = {fields_i.funct7, fields_i.rs2, fields_i.rs1,
                          fields_i.funct3, fields_i.rd, fields_i.opcode};
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    word_c = {fields_i.funct7, imm_i[4:0], fields_i.rs1,
                              fields_i.funct3, fields_i.rd, fields_i.opcode};
                    if (imm_i[11:5] != '0) err_code_c = ERR_SHIFT;
                end else begin
                    word_c = {imm_i[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, fields_i.opcode};
                    if (!fits_signed(imm_i, 12)) err_code_c = ERR_IMM;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                word_c = {imm_i[11:0], fields_i.rs1, fields_i.funct3, fields_i.rd, fields_i.opcode};
                if (!fits_signed(imm_i, 12)) err_code_c = ERR_IMM;
            end
            OPC_STORE: begin
                word_c = {imm_i[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                          imm_i[4:0], fields_i.opcode};
                if (!fits_signed(imm_i, 12)) err_code_c = ERR_IMM;
            end
            OPC_BRANCH: begin
                word_c = {imm_i[12], imm_i[10:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                          imm_i[4:1], imm_i[11], fields_i.opcode};
                if (!fits_signed(imm_i, 13) || imm_i[0]) err_code_c = ERR_IMM;
            end
            OPC_LUI, OPC_AUIPC: begin
                word_c = {imm_i[31:12], fields_i.rd, fields_i.opcode};
                if (imm_i[11:0] != '0) err_code_c = ERR_IMM;
            end
            OPC_JAL: begin
                word_c = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], fields_i.rd, fields_i.opcode};
                if (!fits_signed(imm_i, 21) || imm_i[0]) err_code_c = ERR_IMM;
            end
            default: err_code_c = ERR_OPCODE;
        endcase
    end

endmodule

// File: rtl/insn_encode_loader.sv
// insn_encode_loader: packs decoded instruction tuples into RV32I words and
// writes them at sequential addresses through a 2-entry FIFO.
//   clk, rst   : clock, asynchronous active-low reset
//   start_i    : restart at BASE_ADDR, flush FIFO, clear error and count
//   bus        : tuple input handshake and memory write port (slave view)
//   done_o     : program fully written
//   err_o      : sticky error, err_code_o holds the first error cause
//   count_o    : words written since start
module insn_encode_loader
    import insn_encode_loader_pkg::*;
#(
    parameter int unsigned       DWIDTH    = 32,
    parameter int unsigned       AWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(BASE_ADDR_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    insn_encode_loader_if.slave bus,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         err_code_o,
    output logic [AWIDTH-1:0]  count_o
);

    localparam int unsigned DEPTH = 2;

    state_e            state;
    logic [AWIDTH-1:0] next_addr;
    logic [AWIDTH-1:0] fifo_addr [DEPTH];
    logic [DWIDTH-1:0] fifo_data [DEPTH];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;

    insn_fields_t      fields;
    logic [ILEN-1:0]   pack_word;
    err_code_e         pack_err;

    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic push;
    logic pop;

    always_comb begin
        fields        = '0;
        fields.opcode = bus.opcode_i;
        fields.rd     = bus.rd_i;
        fields.rs1    = bus.rs1_i;
        fields.rs2    = bus.rs2_i;
        fields.funct3 = bus.funct3_i;
        fields.funct7 = bus.funct7_i;
    end

    insn_pack u_pack (
        .fields_i   (fields),
        .imm_i      (ILEN'(bus.imm_i)),
        .word_c     (pack_word),
        .err_code_c (pack_err)
    );

    assign fifo_full  = (fifo_cnt == 2'(DEPTH));
    assign fifo_empty = (fifo_cnt == 2'd0);

    // No pass-through when full: a same-cycle pop does not open the input.
    assign bus.in_ready_o = (state == ST_LOAD) && !fifo_full && !start_i;
    assign accept         = bus.in_valid_i && bus.in_ready_o;
    assign push           = accept && (pack_err == ERR_NONE);
    assign pop            = bus.wr_valid_o && bus.wr_ready_i;

    assign bus.wr_valid_o = !fifo_empty;
    assign bus.wr_addr_o  = fifo_addr[rd_ptr];
    assign bus.wr_data_o  = fifo_data[rd_ptr];

    // FSM, FIFO, address counter and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= '0;
            count_o    <= '0;
            next_addr  <= BASE_ADDR;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else if (start_i) begin
            state      <= ST_LOAD;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            count_o    <= '0;
            next_addr  <= BASE_ADDR;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= '0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= next_addr;
                fifo_data[wr_ptr] <= DWIDTH'(pack_word);
                wr_ptr            <= ~wr_ptr;
                next_addr         <= next_addr + AWIDTH'(4);
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                count_o <= count_o + AWIDTH'(1);
            end
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);

            // Only the first error since start is recorded.
            if (accept && (pack_err != ERR_NONE) && !err_o) begin
                err_o      <= 1'b1;
                err_code_o <= pack_err;
            end

            case (state)
                ST_LOAD: begin
                    if (accept && bus.in_last_i) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_insn_encode_loader.sv
// Self-checking bench for insn_encode_loader: directed program cases plus
// randomized programs checked against a behavioural encoder/loader model.
module tb_insn_encode_loader;

    localparam logic [31:0] BASE = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;
    logic [31:0] count_o;

    insn_encode_loader_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

    insn_encode_loader #(.DWIDTH(32), .AWIDTH(32), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .bus        (bus),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } tup_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: 0 idle, 1 loading, 2 draining, 3 done.
    int          m_phase = 0;
    logic [31:0] m_addr  = BASE;
    logic [31:0] m_count = 0;
    logic        m_err   = 1'b0;
    logic [1:0]  m_code  = 2'b00;
    logic [31:0] mq_addr[$];
    logic [31:0] mq_data[$];
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    logic        last_acc = 1'b0;
    logic        rand_ready = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
    endfunction

    function automatic logic [31:0] at(input logic [31:0] v, input int pos);
        return v << pos;
    endfunction

    // Reference encoder: field placement and numeric range rules of RV32I.
    task automatic ref_encode(input tup_t t, output logic [31:0] word, output logic [1:0] code);
        int s;
        logic [31:0] base;
        s    = $signed(t.imm);
        base = at(t.rs1, 15) | at(t.f3, 12) | 32'(t.op);
        word = 32'h0;
        code = 2'd0;
        case (t.op)
            7'h33: word = at(t.f7, 25) | at(t.rs2, 20) | base | at(t.rd, 7);
            7'h13, 7'h03, 7'h67: begin
                if (t.op == 7'h13 && (t.f3 == 3'd1 || t.f3 == 3'd5)) begin
                    word = at(t.f7, 25) | at(bits(t.imm, 4, 0), 20) | base | at(t.rd, 7);
                    if (bits(t.imm, 11, 5) != 0) code = 2'd3;
                end else begin
                    word = at(bits(t.imm, 11, 0), 20) | base | at(t.rd, 7);
                    if (s < -2048 || s > 2047) code = 2'd2;
                end
            end
            7'h23: begin
                word = at(bits(t.imm, 11, 5), 25) | at(t.rs2, 20) | base | at(bits(t.imm, 4, 0), 7);
                if (s < -2048 || s > 2047) code = 2'd2;
            end
            7'h63: begin
                word = at(bits(t.imm, 12, 12), 31) | at(bits(t.imm, 10, 5), 25) | at(t.rs2, 20) | base
                     | at(bits(t.imm, 4, 1), 8) | at(bits(t.imm, 11, 11), 7);
                if (s < -4096 || s > 4095 || (s % 2) != 0) code = 2'd2;
            end
            7'h37, 7'h17: begin
                word = at(bits(t.imm, 31, 12), 12) | at(t.rd, 7) | 32'(t.op);
                if ((t.imm % 4096) != 0) code = 2'd2;
            end
            7'h6F: begin
                word = at(bits(t.imm, 20, 20), 31) | at(bits(t.imm, 10, 1), 21) | at(bits(t.imm, 11, 11), 20)
                     | at(bits(t.imm, 19, 12), 12) | at(t.rd, 7) | 32'(t.op);
                if (s < -1048576 || s > 1048575 || (s % 2) != 0) code = 2'd2;
            end
            default: code = 2'd1;
        endcase
    endtask

    function automatic tup_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        tup_t t;
        t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.f3 = f3; t.f7 = 7'd0; t.imm = imm;
        return t;
    endfunction

    function automatic tup_t rand_tup();
        tup_t t;
        int v;
        case ($urandom_range(0, 9))
            0: t.op = 7'h33; 1: t.op = 7'h13; 2: t.op = 7'h03; 3: t.op = 7'h67; 4: t.op = 7'h23;
            5: t.op = 7'h63; 6: t.op = 7'h37; 7: t.op = 7'h17; 8: t.op = 7'h6F;
            default: t.op = 7'($urandom);
        endcase
        t.rd  = 5'($urandom); t.rs1 = 5'($urandom); t.rs2 = 5'($urandom);
        t.f3  = 3'($urandom); t.f7  = 7'($urandom);
        case ($urandom_range(0, 4))
            0: begin v = int'($urandom_range(0, 4095)) - 2048; t.imm = 32'(v); end
            1: begin v = (int'($urandom_range(0, 4095)) - 2048) * 2; t.imm = 32'(v); end
            2: t.imm = $urandom & 32'hFFFF_F000;
            3: t.imm = $urandom;
            default: t.imm = 32'($urandom_range(0, 31));
        endcase
        return t;
    endfunction

    task automatic set_tup(input tup_t t, input logic valid, input logic last);
        bus.in_valid_i = valid; bus.in_last_i = last;
        bus.opcode_i = t.op; bus.rd_i = t.rd; bus.rs1_i = t.rs1; bus.rs2_i = t.rs2;
        bus.funct3_i = t.f3; bus.funct7_i = t.f7; bus.imm_i = t.imm;
    endtask

    // One clock: compare outputs with the model, advance the model over the edge.
    task automatic tick();
        logic exp_ready, acc, pop;
        int   sz;
        tup_t t;
        logic [31:0] w;
        logic [1:0]  c;
        if (rand_ready) bus.wr_ready_i = 1'($urandom_range(0, 1));
        #1;
        exp_ready = (m_phase == 1) && (mq_addr.size() < 2) && !start_i;
        check("in_ready", bus.in_ready_o, exp_ready);
        check("wr_valid", bus.wr_valid_o, mq_addr.size() != 0);
        if (mq_addr.size() != 0) begin
            check("wr_addr", bus.wr_addr_o, mq_addr[0]);
            check("wr_data", bus.wr_data_o, mq_data[0]);
        end
        check("count", count_o, m_count);
        check("err", err_o, m_err);
        check("err_code", err_code_o, m_code);
        check("done", done_o, m_phase == 3);
        acc = bus.in_valid_i && exp_ready;
        pop = (mq_addr.size() != 0) && bus.wr_ready_i;
        sz  = mq_addr.size();
        last_acc = acc;
        if (start_i) begin
            mq_addr.delete(); mq_data.delete();
            m_addr = BASE; m_count = 0; m_err = 1'b0; m_code = 2'd0; m_phase = 1;
        end else begin
            if (pop) begin
                wlog_addr.push_back(bus.wr_addr_o);
                wlog_data.push_back(bus.wr_data_o);
                void'(mq_addr.pop_front()); void'(mq_data.pop_front());
                m_count++;
            end
            if (m_phase == 2 && sz == 0) m_phase = 3;
            if (acc) begin
                t.op = bus.opcode_i; t.rd = bus.rd_i; t.rs1 = bus.rs1_i; t.rs2 = bus.rs2_i;
                t.f3 = bus.funct3_i; t.f7 = bus.funct7_i; t.imm = bus.imm_i;
                ref_encode(t, w, c);
                if (c == 2'd0) begin
                    mq_addr.push_back(m_addr); mq_data.push_back(w);
                    m_addr += 32'd4;
                end else if (!m_err) begin
                    m_err = 1'b1; m_code = c;
                end
                if (bus.in_last_i) m_phase = 2;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        wlog_addr.delete(); wlog_data.delete();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic offer(input tup_t t, input logic last);
        set_tup(t, 1'b1, last);
        last_acc = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) check("offer_timeout", 1'b0, 1'b1);
        bus.in_valid_i = 1'b0; bus.in_last_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (done_o) break;
            tick();
        end
        check("done_reached", done_o, 1'b1);
    endtask

    initial begin
        tup_t t;
        set_tup(mk(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0), 1'b0, 1'b0);
        bus.wr_ready_i = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_in_ready", bus.in_ready_o, 1'b0);
        check("rst_wr_valid", bus.wr_valid_o, 1'b0);
        check("rst_wr_addr", bus.wr_addr_o, 32'h0);
        check("rst_wr_data", bus.wr_data_o, 32'h0);
        check("rst_done", done_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_err_code", err_code_o, 2'b00);
        check("rst_count", count_o, 32'h0);
        rst = 1'b1;
        tick();

        // addi x1,x0,5
        bus.wr_ready_i = 1'b1;
        do_start();
        offer(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5), 1'b1);
        wait_done();
        check("addi_n", wlog_addr.size(), 1);
        if (wlog_addr.size() >= 1) begin
            check("addi_addr", wlog_addr[0], BASE);
            check("addi_data", wlog_data[0], 32'h0050_0093);
        end
        check("addi_count", count_o, 32'd1);

        // beq x1,x2,-4 ; jal x1,8
        do_start();
        offer(mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC), 1'b0);
        offer(mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8), 1'b1);
        wait_done();
        check("bj_n", wlog_addr.size(), 2);
        if (wlog_addr.size() >= 2) begin
            check("beq_data", wlog_data[0], 32'hFE20_8EE3);
            check("beq_addr", wlog_addr[0], BASE);
            check("jal_data", wlog_data[1], 32'h0080_00EF);
            check("jal_addr", wlog_addr[1], BASE + 32'd4);
        end

        // sw x2,8(x1) ; lui x5,0x12345000
        do_start();
        offer(mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8), 1'b0);
        offer(mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000), 1'b1);
        wait_done();
        check("su_n", wlog_addr.size(), 2);
        if (wlog_addr.size() >= 2) begin
            check("sw_data", wlog_data[0], 32'h0020_A423);
            check("lui_data", wlog_data[1], 32'h1234_52B7);
        end

        // Back-pressure: two tuples fill the FIFO, third stalls
        bus.wr_ready_i = 1'b0;
        do_start();
        offer(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1), 1'b0);
        offer(mk(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2), 1'b0);
        set_tup(mk(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_acc", last_acc, 1'b0);
        end
        check("stall_ready", bus.in_ready_o, 1'b0);
        bus.wr_ready_i = 1'b1;
        offer(mk(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3), 1'b1);
        wait_done();
        check("stall_n", wlog_addr.size(), 3);
        if (wlog_addr.size() >= 3) begin
            check("stall_a0", wlog_addr[0], BASE);
            check("stall_a1", wlog_addr[1], BASE + 32'd4);
            check("stall_a2", wlog_addr[2], BASE + 32'd8);
            check("stall_d2", wlog_data[2], 32'h0030_0193);
        end

        // Misaligned branch, then valid addi, then bad opcode
        do_start();
        offer(mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3), 1'b0);
        tick();
        check("err_flag", err_o, 1'b1);
        check("err_first", err_code_o, 2'b10);
        offer(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5), 1'b0);
        offer(mk(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd0), 1'b1);
        wait_done();
        check("err_n", wlog_addr.size(), 1);
        if (wlog_addr.size() >= 1) check("err_next_addr", wlog_addr[0], BASE);
        check("err_kept", err_code_o, 2'b10);

        // Reset during DRAIN with two words queued
        bus.wr_ready_i = 1'b0;
        do_start();
        offer(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1), 1'b0);
        offer(mk(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2), 1'b1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_wr_valid", bus.wr_valid_o, 1'b0);
        check("mid_rst_wr_addr", bus.wr_addr_o, 32'h0);
        check("mid_rst_wr_data", bus.wr_data_o, 32'h0);
        check("mid_rst_in_ready", bus.in_ready_o, 1'b0);
        check("mid_rst_done", done_o, 1'b0);
        check("mid_rst_err", err_o, 1'b0);
        check("mid_rst_count", count_o, 32'h0);
        mq_addr.delete(); mq_data.delete();
        m_phase = 0; m_addr = BASE; m_count = 0; m_err = 1'b0; m_code = 2'd0;
        @(negedge clk);
        rst = 1'b1;
        bus.wr_ready_i = 1'b1;
        do_start();
        offer(mk(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd7), 1'b1);
        wait_done();
        check("post_rst_n", wlog_addr.size(), 1);
        if (wlog_addr.size() >= 1) check("post_rst_addr", wlog_addr[0], BASE);

        // Randomized programs with random write back-pressure
        rand_ready = 1'b1;
        for (int p = 0; p < 20; p++) begin
            int n;
            n = int'($urandom_range(1, 8));
            do_start();
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                if ((p % 4) == 3 && i == n / 2) do_start();
                t = rand_tup();
                offer(t, i == n - 1);
            end
            wait_done();
        end
        rand_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/insn_encode_loader.md
Name: insn_encode_loader

Overview:
- Inverse of the decode stage: accepts decoded instruction fields (opcode, rd, rs1, rs2, funct3, funct7, imm) over a valid/ready handshake and packs them into 32-bit RV32I instruction words.
- Writes the packed words at sequential addresses into the instruction-memory write port through a 2-entry output FIFO.
- Used by the testbench and boot path to load programs; also range-checks immediates.

Parameters:
- DWIDTH, 32, instruction/data width
- AWIDTH, 32, address width
- BASE_ADDR, 32'h0100_0000, first write address after start

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- start_i  input  1  one-cycle pulse: restart load at BASE_ADDR, flush FIFO, clear error
- in_valid_i  input  1  field tuple valid
- in_ready_o  output  1  tuple accepted when in_valid_i && in_ready_o at posedge
- in_last_i  input  1  marks final tuple of program
- opcode_i  input  7  opcode
- rd_i, rs1_i, rs2_i  input  5 each  register IDs
- funct3_i  input  3  funct3
- funct7_i  input  7  funct7
- imm_i  input  DWIDTH  sign-extended immediate, same form as decode imm_o
- wr_valid_o  output  1  write request valid
- wr_ready_i  input  1  memory accepts write
- wr_addr_o  output  AWIDTH  write address
- wr_data_o  output  DWIDTH  encoded instruction
- done_o  output  1  program fully written
- err_o  output  1  sticky error flag
- err_code_o  output  2  first error: 00 none, 01 bad opcode, 10 imm out of range/misaligned, 11 shift imm[11:5] nonzero
- count_o  output  AWIDTH  number of words written

Behaviour:
- Reset (rst low, async) forces state IDLE, FIFO empty, address = BASE_ADDR; in_ready_o, wr_valid_o, done_o, err_o = 0; err_code_o, count_o, wr_addr_o, wr_data_o = 0.
- FSM:
  - IDLE -> LOAD on start_i.
  - LOAD -> DRAIN when the accepted tuple has in_last_i.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE -> LOAD on start_i.
  - start_i in any state -> LOAD, FIFO flushed, address = BASE_ADDR, err cleared, count_o = 0.
- in_ready_o = (state == LOAD) && (FIFO not full) && !start_i. There is no full-FIFO pass-through, even when a pop occurs in the same cycle.
- Encoding (combinational, inside the sub-module):
  - R: funct7|rs2|rs1|f3|rd|op.
  - I (OP-IMM, LOAD, JALR): imm[11:0]|rs1|f3|rd|op.
  - OP-IMM shifts (f3 = 001/101): funct7_i|imm[4:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Range checks:
  - I/S: imm must equal sign-extension of imm[11:0].
  - B: sign-extension of imm[12:0], with imm[0] = 0.
  - J: sign-extension of imm[20:0], with imm[0] = 0.
  - U: imm[11:0] = 0.
  - Shift: imm[11:5] = 0.
  - Opcode must be one of the 9 RV32I opcodes above.
- Accepted valid tuple: pushed {addr, word}; address += 4 (wraps mod 2^AWIDTH); wr_valid_o high starting the cycle after acceptance (latency 1).
- Accepted erroneous tuple: consumed but not pushed; address not incremented; err_o set; err_code_o latches only the first error. Loading continues, and in_last_i is honoured.
- FIFO pop on wr_valid_o && wr_ready_i: count_o increments. Output is held stable while wr_ready_i is low.
- Push and pop in the same cycle: occupancy unchanged, order preserved.
- done_o is high only in DONE.
- Reset mid-operation discards the FIFO contents with no partial writes.

Decomposition:
- Opcode and funct3 constants come from the existing shared constants package.
- Add to the same package: err_code enum, FSM state enum {IDLE, LOAD, DRAIN, DONE}, and BASE_ADDR default.
- One sub-module: insn_pack (pure combinational encoder and range checker, outputs word + err_code).
- FIFO and FSM stay in the top level.

Test Plan:
- start; addi x1,x0,5 (op 0x13, rd 1, imm 5) -> wr_addr 0x01000000, wr_data 0x00500093, count_o 1.
- beq x1,x2,imm=-4 then jal x1,imm=8 (last) -> 0xFE208EE3 @0x01000000, 0x008000EF @0x01000004; done_o after drain.
- sw x2,8(x1); lui x5,imm=0x12345000 -> 0x0020A423, 0x123452B7.
- wr_ready_i held 0, three tuples offered -> two accepted, in_ready_o low, third stalls; release -> in-order writes at +0/+4/+8.
- branch imm=3 -> err_o 1, err_code 10, no write, next valid tuple still written at 0x01000000; a later bad opcode leaves code 10.
- rst low mid-DRAIN with 2 queued -> all outputs zero immediately; after start, address restarts at 0x01000000.
